multdiv_16: RTL
===============

Name: multdiv_16

Overview:
- Iterative signed 16-bit multiply/divide unit, paired with alu_16 in the execute stage.
- Handles the long-latency MUL and DIV operations that the single-cycle ALU does not implement.
- Accepts an operation with a one-cycle start pulse, computes over a fixed number of cycles, and returns the result, an exception flag and a one-cycle ready pulse.
- The pipeline controller stalls on this block until the ready pulse arrives.

Parameters:
- WIDTH, 16, operand and result width. Only 16 needs to be supported; the iteration count equals WIDTH.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- data_operandA  input  16  multiplicand / dividend, two's complement
- data_operandB  input  16  multiplier / divisor, two's complement
- ctrl_MULT  input  1  start-multiply pulse
- ctrl_DIV  input  1  start-divide pulse
- data_result  output  16  product low half / quotient
- data_exception  output  1  overflow or divide-by-zero
- data_resultRDY  output  1  one-cycle result-valid pulse

Behaviour:
- Reset: one clock; reset_n is asynchronous and active-low.
  - While reset_n=0: state=IDLE, data_result=0, data_exception=0, data_resultRDY=0, internal counter/registers=0.
  - Deassertion takes effect at the next rising edge.
- States:
  - IDLE: no operation pending.
  - RUN_MUL / RUN_DIV: iterating; the counter counts 0..15.
  - DONE: present for exactly one cycle.
- Start: sampled only in IDLE or DONE.
  - ctrl_MULT=1 → RUN_MUL; else ctrl_DIV=1 → RUN_DIV. MULT wins if both are high.
  - data_operandA and data_operandB are latched at that edge. Later operand changes have no effect.
- Start pulses in RUN_* are ignored. No queuing.
- Latency: if start is sampled at edge E, the block performs one iteration per edge and reaches DONE at edge E+16.
  - data_resultRDY=1 for the single cycle between E+16 and E+17, then the block returns to IDLE.
  - Latency is the same for every operand value, including the exception cases.
- Back-to-back: a start sampled at the DONE-exit edge (E+16→E+17) is accepted. The new RDY pulse occurs 16 edges later.
- Output holding: data_result and data_exception update only on entry to DONE. They hold their values until the next DONE or reset; they do not return to 0 in IDLE.
- Multiply:
  - data_result = low 16 bits of the signed 32-bit product A×B.
  - data_exception=1 iff the signed product is outside [-32768, 32767].
  - Any algorithm (Booth, or magnitude shift-add with sign fix) is acceptable if the results are bit-exact.
- Divide:
  - Signed quotient, truncated toward zero. The remainder is discarded.
  - B=0: data_result=0, data_exception=1.
  - A=-32768, B=-1: data_result=0x8000, data_exception=1.
  - Otherwise data_exception=0.
- Reset mid-operation: the operation is aborted immediately, no RDY pulse is produced, and the block is in IDLE afterward.
- No X propagation: every register has a defined reset value.

Test Plan:
- Reset with reset_n=0 asynchronously mid-cycle → all outputs 0 immediately. Then MULT A=7, B=-3 → exactly 16 cycles later RDY=1 for 1 cycle, result=0xFFEB (-21), exception=0.
- MULT A=300, B=200 (60000) → result=0xEA60, exception=1. MULT A=-128, B=256 → result=0x8000, exception=0.
- DIV A=-7, B=2 → result=0xFFFD (-3), exception=0. DIV A=100, B=0 → result=0, exception=1, RDY still at cycle 16.
- DIV A=0x8000, B=0xFFFF → result=0x8000, exception=1. Pulse ctrl_DIV again 5 cycles into that operation → ignored, only one RDY pulse.
- Assert ctrl_MULT and ctrl_DIV together with A=6, B=3 → result=18 (multiply). Issue ctrl_DIV A=6, B=3 in the DONE cycle → second RDY 16 cycles later with result=2. Result stays 18 between the two pulses.
- Start MULT, drop reset_n at iteration 8 → no RDY pulse, outputs 0. Restart DIV A=9, B=-3 → result=0xFFFD, latency 16.

Source files
------------

// File: rtl/multdiv_16.sv
// Iterative signed 16-bit multiply / divide unit for the execute stage.
// A start pulse latches the operand magnitudes; WIDTH iterations of
// shift-add (multiply) or restoring subtraction (divide) follow, the sign
// fix-up and exception check are folded into the last iteration, and a
// one-cycle ready pulse is raised from the DONE state.
module multdiv_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN_MUL = 2'd1,
        RUN_DIV = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mag_b;      // |B|: multiplicand or divisor
    logic [WIDTH-1:0] work_hi;    // product high half / partial remainder
    logic [WIDTH-1:0] work_lo;    // multiplier bits / dividend-quotient shifter
    logic             neg;        // result sign, sign(A) xor sign(B)
    logic             b_zero;     // divisor was zero

    logic             accept;
    logic             running;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;

    // Two's complement magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : v;
    endfunction

    // Apply sign to the full-width magnitude product; overflow when the
    // upper half is not a pure sign extension of the low half.
    function automatic logic [WIDTH:0] mul_finish(input logic [2*WIDTH-1:0] mag,
                                                  input logic              neg_f);
        logic signed [2*WIDTH-1:0] p;
        p = neg_f ? -$signed(mag) : $signed(mag);
        return {(p[2*WIDTH-1:WIDTH] != {WIDTH{p[WIDTH-1]}}), p[WIDTH-1:0]};
    endfunction

    // Apply sign to the magnitude quotient. A positive quotient with the top
    // bit set can only be -2^(WIDTH-1) / -1, which saturates to 0x8000.
    function automatic logic [WIDTH:0] div_finish(input logic [WIDTH-1:0] q,
                                                  input logic             neg_f,
                                                  input logic             zero_f);
        logic [WIDTH-1:0] r;
        r = neg_f ? -q : q;
        if (zero_f)
            return {1'b1, {WIDTH{1'b0}}};
        return {~neg_f & q[WIDTH-1], r};
    endfunction

    assign accept  = ((state == IDLE) || (state == DONE)) && (ctrl_MULT || ctrl_DIV);
    assign running = (state == RUN_MUL) || (state == RUN_DIV);

    // One iteration of the selected algorithm, computed from the current work registers.
    always_comb begin
        mul_sum   = {1'b0, work_hi} + ({(WIDTH+1){work_lo[0]}} & {1'b0, mag_b});
        div_shift = {work_hi, work_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mag_b});
        if (state == RUN_DIV) begin
            hi_n = div_ge ? (div_shift[WIDTH-1:0] - mag_b) : div_shift[WIDTH-1:0];
            lo_n = {work_lo[WIDTH-2:0], div_ge};
        end else begin
            hi_n = mul_sum[WIDTH:1];
            lo_n = {mul_sum[0], work_lo[WIDTH-1:1]};
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state and ready pulse; MULT has priority when both starts are high.
    always_comb begin
        state_next     = state;
        data_resultRDY = 1'b0;
        case (state)
            IDLE, DONE: begin
                data_resultRDY = (state == DONE);
                if (ctrl_MULT)
                    state_next = RUN_MUL;
                else if (ctrl_DIV)
                    state_next = RUN_DIV;
                else
                    state_next = IDLE;
            end
            RUN_MUL, RUN_DIV: begin
                if (cnt == LAST)
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, iteration registers and held result outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt            <= '0;
            mag_b          <= '0;
            work_hi        <= '0;
            work_lo        <= '0;
            neg            <= 1'b0;
            b_zero         <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            mag_b   <= magnitude(data_operandB);
            work_hi <= '0;
            work_lo <= magnitude(data_operandA);
            neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            b_zero  <= (data_operandB == '0);
        end else if (running) begin
            cnt     <= cnt + 1'b1;
            work_hi <= hi_n;
            work_lo <= lo_n;
            if (cnt == LAST) begin
                if (state == RUN_MUL)
                    {data_exception, data_result} <= mul_finish({hi_n, lo_n}, neg);
                else
                    {data_exception, data_result} <= div_finish(lo_n, neg, b_zero);
            end
        end
    end

endmodule
